des3_axi4lite_sequencer: RTL
============================

# des3_axi4lite_sequencer

Hardware job sequencer that sits directly upstream of the AXI4-lite Triple-DES slave (des3_top_axi4lite) and drives its register interface as a single-master AXI4-lite initiator. It accepts one 3DES job (three 64-bit keys, one 64-bit block, direction) over a valid/ready port. It then writes keys, input and control registers, polls DONE, reads back the 64-bit result and returns it with an error status. This lets cores or DMA logic offload 3DES without issuing individual bus transactions.

## Interface
- AW, 32, AXI address width
- DW, 32, AXI data width (only 32 supported)
- BASE_ADDR, 32'h0, base address of the DES3 slave
- KEY_OFF, 'h00, key base (6 words); IN_OFF, 'h18, input base (2 words); CT_OFF, 'h20, result base (2 words)
- START_OFF, 'h28; DECRYPT_OFF, 'h2C; DONE_OFF, 'h30
- POLL_MAX, 1024, maximum DONE reads before timeout (>=1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- i_job_valid / o_job_ready  in/out  1  job handshake
- i_job_key  in  192  {key1,key2,key3}, key1 in [191:128]
- i_job_block  in  64  plaintext or ciphertext
- i_job_decrypt  in  1  1 = decrypt
- o_res_valid / i_res_ready  out/in  1  result handshake
- o_res_block  out  64  result block
- o_res_err  out  2  bit0 bus error (non-OKAY bresp/rresp), bit1 poll timeout
- o_axi_awaddr out AW; o_axi_awprot out 3 (3'b000); o_axi_awvalid out 1; i_axi_awready in 1
- o_axi_wdata out 32; o_axi_wstrb out 4 (4'hF); o_axi_wvalid out 1; i_axi_wready in 1
- i_axi_bresp in 2; i_axi_bvalid in 1; o_axi_bready out 1
- o_axi_araddr out AW; o_axi_arprot out 3 (3'b000); o_axi_arvalid out 1; i_axi_arready in 1
- i_axi_rdata in 32; i_axi_rresp in 2; i_axi_rvalid in 1; o_axi_rready out 1

## Operation
- States: IDLE, WR_REQ, WR_RESP, POLL_REQ, POLL_RESP, RD_REQ, RD_RESP, RESULT.
- IDLE: o_job_ready=1. On handshake, latch key, block and decrypt. Clear step counter, poll counter and error. Go to WR_REQ.
- Write steps 0..9 (addresses relative to BASE_ADDR):
  - steps 0..5: key word j to KEY_OFF+(5-j)*4. Word j is bits [191-32j -: 32] (key1 hi first).
  - step 6: block[63:32] to IN_OFF+4; step 7: block[31:0] to IN_OFF+0.
  - step 8: {31'b0,decrypt} to DECRYPT_OFF (written every job).
  - step 9: 32'h1 to START_OFF.
- WR_REQ: assert awvalid and wvalid together. Each drops independently on its own handshake; per-channel done flags are held. Go to WR_RESP once both are done.
- WR_RESP: bready=1. On bvalid, bresp!=OKAY sets err[0] and jumps to RESULT. Otherwise step 9 goes to POLL_REQ, other steps return to WR_REQ with step+1.
- POLL: read DONE_OFF. rdata[0]=1 goes to RD_REQ.
  - rdata[0]=0 increments the poll counter. When the counter reaches POLL_MAX, set err[1] and go to RESULT; otherwise re-poll.
- RD steps 0..1: read CT_OFF+4j into block[63-32j -: 32]. After step 1, go to RESULT.
- Any rresp!=OKAY sets err[0] and jumps to RESULT.
- RESULT: o_res_valid=1. o_res_block is 0 when err!=0. On res handshake, return to IDLE.
- Only one AXI transaction is outstanding at any time; AW/W never run ahead of B.

## Timing
- Reset values: all AXI valids, bready, rready, o_res_valid = 0; o_res_block=0; o_res_err=0. State IDLE, so o_job_ready=1 from the first cycle after rst_ni high.
- Valid/address/data are registered; once asserted, they are held stable until their handshake completes (AXI rule).
- Zero-wait slave (ready high, response the cycle after the handshake), DONE on first poll:
  - each transaction takes 2 cycles;
  - o_res_valid rises 27 cycles after the job-accept edge.
- Each extra poll adds 2 cycles. Slave stalls extend the timing cycle-for-cycle.
- A response arriving in the same cycle as the request handshake is not possible, because bready/rready are asserted only in the *_RESP states.
- Reset mid-job: the next edge returns to IDLE and drops all valids. The in-flight transaction is abandoned; the slave shares the reset.
- o_res_valid is held until i_res_ready, with the result stable. A new job is not accepted in RESULT.

## Test plan
- Encrypt, keys all 0123456789ABCDEF, block 736F6D6564617461, decrypt=0 -> o_res_block=3D124FE2198BA318, err=0, 27 cycles with a zero-wait slave model.
- Decrypt, keys 0352020767208217/8602876659082198/64056ABDFEA93457, block c07d2a0fa566fa30 -> 7371756967676C65. Check the write log: 10 writes at addresses 'h14,'h10,'h0C,'h08,'h04,'h00,'h1C,'h18,'h2C,'h28, with DECRYPT data 1.
- Random awready/wready/bvalid/arready/rvalid stalls with AW and W accepted in different cycles -> no duplicate writes, valids stable until handshake, correct result.
- Slave returns SLVERR on step-3 bresp -> no further AXI requests; result err=2'b01, block 0.
- POLL_MAX=4, DONE never set -> exactly 4 DONE reads, err=2'b10.
- i_res_ready held low 10 cycles, then rst_ni low mid-job on a second job -> result stable while held; after reset all valids=0 and o_job_ready=1.

Source files
------------

// File: rtl/des3_axi4lite_sequencer.sv
// rtl/des3_axi4lite_sequencer.sv - AXI4-lite initiator that runs one 3DES job on the DES3 slave
//
// Purpose: accepts a 3DES job (keys, block, direction). It writes the slave's key, input,
// decrypt and start registers and polls DONE. It then reads the 64-bit result back and
// returns it with an error status. Only one AXI transaction is outstanding at a time.
//
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   i_job_valid/o_job_ready        job handshake; i_job_key {key1,key2,key3},
//                                  i_job_block, i_job_decrypt
//   o_res_valid/i_res_ready        result handshake; o_res_block, o_res_err
//                                  (bit0 bus error, bit1 poll timeout)
//   o_axi_aw*/w*/b*/ar*/r*         AXI4-lite master channels
module des3_axi4lite_sequencer #(
  parameter int              AW          = 32,
  parameter int              DW          = 32,
  parameter logic [AW-1:0]   BASE_ADDR   = '0,
  parameter logic [AW-1:0]   KEY_OFF     = 'h00,
  parameter logic [AW-1:0]   IN_OFF      = 'h18,
  parameter logic [AW-1:0]   CT_OFF      = 'h20,
  parameter logic [AW-1:0]   START_OFF   = 'h28,
  parameter logic [AW-1:0]   DECRYPT_OFF = 'h2C,
  parameter logic [AW-1:0]   DONE_OFF    = 'h30,
  parameter int              POLL_MAX    = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_job_valid,
  output logic            o_job_ready,
  input  logic [191:0]    i_job_key,
  input  logic [63:0]     i_job_block,
  input  logic            i_job_decrypt,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic [63:0]     o_res_block,
  output logic [1:0]      o_res_err,
  output logic [AW-1:0]   o_axi_awaddr,
  output logic [2:0]      o_axi_awprot,
  output logic            o_axi_awvalid,
  input  logic            i_axi_awready,
  output logic [DW-1:0]   o_axi_wdata,
  output logic [DW/8-1:0] o_axi_wstrb,
  output logic            o_axi_wvalid,
  input  logic            i_axi_wready,
  input  logic [1:0]      i_axi_bresp,
  input  logic            i_axi_bvalid,
  output logic            o_axi_bready,
  output logic [AW-1:0]   o_axi_araddr,
  output logic [2:0]      o_axi_arprot,
  output logic            o_axi_arvalid,
  input  logic            i_axi_arready,
  input  logic [DW-1:0]   i_axi_rdata,
  input  logic [1:0]      i_axi_rresp,
  input  logic            i_axi_rvalid,
  output logic            o_axi_rready
);

  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_POLL_REQ, S_POLL_RESP, S_RD_REQ, S_RD_RESP, S_RESULT
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      step_q, step_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [1:0]      err_q, err_d;
  logic [191:0]    key_q, key_d;
  logic [63:0]     blk_q, blk_d;
  logic            dec_q, dec_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [AW-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic            res_valid_q, res_valid_d;

  // Write order: key words low address last-to-first, block hi word first, decrypt, start.
  function automatic logic [AW-1:0] wr_addr(input logic [3:0] s);
    logic [AW-1:0] off;
    off = START_OFF;
    if (s < 4'd6)       off = KEY_OFF + (AW'(4'd5 - s) << 2);
    else if (s == 4'd6) off = IN_OFF + AW'(4);
    else if (s == 4'd7) off = IN_OFF;
    else if (s == 4'd8) off = DECRYPT_OFF;
    return BASE_ADDR + off;
  endfunction

  function automatic logic [31:0] wr_data(input logic [3:0] s, input logic [191:0] k,
                                          input logic [63:0] b, input logic d);
    logic [31:0] v;
    case (s)
      4'd0:    v = k[191:160];
      4'd1:    v = k[159:128];
      4'd2:    v = k[127:96];
      4'd3:    v = k[95:64];
      4'd4:    v = k[63:32];
      4'd5:    v = k[31:0];
      4'd6:    v = b[63:32];
      4'd7:    v = b[31:0];
      4'd8:    v = {31'b0, d};
      default: v = 32'h1;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      poll_q      <= '0;
      err_q       <= '0;
      key_q       <= '0;
      blk_q       <= '0;
      dec_q       <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      poll_q      <= poll_d;
      err_q       <= err_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      dec_q       <= dec_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    poll_d    = poll_q;
    err_d     = err_q;
    key_d     = key_q;
    blk_d     = blk_q;
    dec_d     = dec_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: if (i_job_valid) begin
        key_d     = i_job_key;
        blk_d     = i_job_block;
        dec_d     = i_job_decrypt;
        step_d    = '0;
        poll_d    = '0;
        err_d     = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = S_WR_REQ;
      end
      S_WR_REQ: begin
        // AW and W may be accepted in different cycles; remember each until both are in.
        aw_done_d = aw_done_q | (awvalid_q & i_axi_awready);
        w_done_d  = w_done_q | (wvalid_q & i_axi_wready);
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: if (i_axi_bvalid) begin
        if (i_axi_bresp != 2'b00) begin
          err_d[0] = 1'b1;
          state_d  = S_RESULT;
        end else if (step_q == 4'd9) begin
          step_d  = '0;
          state_d = S_POLL_REQ;
        end else begin
          step_d  = step_q + 4'd1;
          state_d = S_WR_REQ;
        end
      end
      S_POLL_REQ: if (arvalid_q && i_axi_arready) state_d = S_POLL_RESP;
      S_POLL_RESP: if (i_axi_rvalid) begin
        if (i_axi_rresp != 2'b00) begin
          err_d[0] = 1'b1;
          state_d  = S_RESULT;
        end else if (i_axi_rdata[0]) begin
          step_d  = '0;
          state_d = S_RD_REQ;
        end else begin
          poll_d = poll_q + PW'(1);
          if (poll_d == PW'(POLL_MAX)) begin
            err_d[1] = 1'b1;
            state_d  = S_RESULT;
          end else begin
            state_d = S_POLL_REQ;
          end
        end
      end
      S_RD_REQ: if (arvalid_q && i_axi_arready) state_d = S_RD_RESP;
      S_RD_RESP: if (i_axi_rvalid) begin
        if (i_axi_rresp != 2'b00) begin
          err_d[0] = 1'b1;
          state_d  = S_RESULT;
        end else if (step_q[0]) begin
          blk_d[31:0] = i_axi_rdata;
          state_d     = S_RESULT;
        end else begin
          blk_d[63:32] = i_axi_rdata;
          step_d       = 4'd1;
          state_d      = S_RD_REQ;
        end
      end
      S_RESULT: if (res_valid_q && i_res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus-facing outputs are registered from the next state, so a request appears on the
  // same edge that enters its *_REQ state and stays put while that state holds.
  // o_res_valid lags entry to RESULT by one cycle.
  always_comb begin
    awvalid_d   = (state_d == S_WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == S_WR_REQ) && !w_done_d;
    awaddr_d    = wr_addr(step_d);
    wdata_d     = wr_data(step_d, key_d, blk_d, dec_d);
    bready_d    = (state_d == S_WR_RESP);
    arvalid_d   = (state_d == S_POLL_REQ) || (state_d == S_RD_REQ);
    araddr_d    = BASE_ADDR + ((state_d == S_RD_REQ) ?
                  (CT_OFF + (step_d[0] ? AW'(4) : AW'(0))) : DONE_OFF);
    rready_d    = (state_d == S_POLL_RESP) || (state_d == S_RD_RESP);
    res_valid_d = (state_q == S_RESULT) && (state_d == S_RESULT);
  end

  assign o_job_ready   = (state_q == S_IDLE);
  assign o_res_valid   = res_valid_q;
  assign o_res_block   = (state_q == S_RESULT && err_q == 2'b00) ? blk_q : 64'h0;
  assign o_res_err     = err_q;
  assign o_axi_awaddr  = awaddr_q;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_awvalid = awvalid_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = '1;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_bready  = bready_q;
  assign o_axi_araddr  = araddr_q;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_rready  = rready_q;

endmodule
